// File: rtl/video_timing_fb_swap_if.sv
// Front-buffer swap bus between the CPU-side requester (master) and the
// video timing / double-buffer controller (slave).
interface video_timing_fb_swap_if;
    logic [24:0] back_addr;
    logic        swap_req;
    logic [24:0] fb_base_addr;
    logic        swap_pending;
    logic        swap_done;

    modport master (
        output back_addr,
        output swap_req,
        input  fb_base_addr,
        input  swap_pending,
        input  swap_done
    );

    modport slave (
        input  back_addr,
        input  swap_req,
        output fb_base_addr,
        output swap_pending,
        output swap_done
    );
endinterface

// File: rtl/video_timing_fb_swap.sv
// Pixel-clock raster timing generator plus tear-free front-buffer swap controller.
// Optional frame counter enabled by defining VIDEO_TIMING_FRAME_CNT_EN.
module video_timing_fb_swap #(
    parameter int          H_BPORCH      = 40,
    parameter int          H_ACTIVE      = 320,
    parameter int          H_TOTAL       = 400,
    parameter int          V_BPORCH      = 16,
    parameter int          V_ACTIVE      = 240,
    parameter int          V_TOTAL       = 512,
    parameter int          HS_POS        = 3,
    parameter logic [24:0] RESET_FB_ADDR = 25'h0
) (
    input  logic                         clk_video,
    input  logic                         reset_n,
    output logic [9:0]                   x_count,
    output logic [9:0]                   y_count,
    output logic                         line_start,
    output logic                         vid_hs,
    output logic                         vid_vs,
    output logic                         vid_de,
    output logic                         vblank,
    output logic [15:0]                  frame_count,
    video_timing_fb_swap_if.slave        swap_bus
);

    // Active-window bounds kept 11 bits wide so an end bound of 1024 still compares correctly.
    localparam logic [9:0]  X_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST      = 10'(V_TOTAL - 1);
    localparam logic [10:0] X_ACT_FIRST = 11'(H_BPORCH);
    localparam logic [10:0] X_ACT_END   = 11'(H_BPORCH + H_ACTIVE);
    localparam logic [10:0] Y_ACT_FIRST = 11'(V_BPORCH);
    localparam logic [10:0] Y_ACT_END   = 11'(V_BPORCH + V_ACTIVE);
    localparam logic [9:0]  Y_ACT_LAST  = 10'(V_BPORCH + V_ACTIVE - 1);
    localparam logic [9:0]  HS_X        = 10'(HS_POS);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

    logic        x_wrap;
    logic        y_wrap;
    logic        h_act;
    logic        v_act;
    logic        boundary;

    swap_state_t state_q;
    swap_state_t state_d;
    logic [24:0] pending_q;
    logic [24:0] pending_d;
    logic [24:0] fb_q;
    logic [24:0] fb_d;
    logic        done_q;
    logic        done_d;

    assign x_wrap = (x_count == X_LAST);
    assign y_wrap = (y_count == Y_LAST);

    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            x_count <= 10'd0;
            y_count <= 10'd0;
        end else if (x_wrap) begin
            x_count <= 10'd0;
            y_count <= y_wrap ? 10'd0 : y_count + 10'd1;
        end else begin
            x_count <= x_count + 10'd1;
        end
    end

    assign line_start = (x_count == 10'd0);
    assign h_act      = ({1'b0, x_count} >= X_ACT_FIRST) && ({1'b0, x_count} < X_ACT_END);
    assign v_act      = ({1'b0, y_count} >= Y_ACT_FIRST) && ({1'b0, y_count} < Y_ACT_END);
    assign vblank     = !v_act;

    // One-cycle delay lines up sync/enable with the scanout stage's registered pixel.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            vid_de <= 1'b0;
            vid_hs <= 1'b0;
            vid_vs <= 1'b0;
        end else begin
            vid_de <= h_act && v_act;
            vid_hs <= (x_count == HS_X);
            vid_vs <= (x_count == HS_X) && (y_count == 10'd0);
        end
    end

    // Last clock of the last active line: the only cycle the front buffer may change.
    assign boundary = x_wrap && (y_count == Y_ACT_LAST);

    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= 25'h0;
            fb_q      <= RESET_FB_ADDR;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            fb_q      <= fb_d;
            done_q    <= done_d;
        end
    end

    // A request landing on the boundary is queued for the next frame, never merged into this swap.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        fb_d      = fb_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_bus.swap_req) begin
                    pending_d = swap_bus.back_addr;
                    state_d   = PENDING;
                end
            end
            PENDING: begin
                if (boundary) begin
                    fb_d    = pending_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                if (swap_bus.swap_req) begin
                    pending_d = swap_bus.back_addr;
                    state_d   = PENDING;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign swap_bus.fb_base_addr = fb_q;
    assign swap_bus.swap_pending = (state_q == PENDING);
    assign swap_bus.swap_done    = done_q;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [15:0] frame_q;

    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            frame_q <= 16'h0;
        end else if (x_wrap && y_wrap) begin
            frame_q <= frame_q + 16'h1;
        end
    end

    assign frame_count = frame_q;
`else
    assign frame_count = 16'h0;
`endif

endmodule

// File: tb/tb_video_timing_fb_swap.sv
// Directed bench for video_timing_fb_swap on a shrunken raster, checked every
// cycle against a time-indexed model of the raster and the swap rules.
module tb_video_timing_fb_swap;

    localparam int          HB       = 5;
    localparam int          HA       = 10;
    localparam int          HT       = 20;
    localparam int          VB       = 3;
    localparam int          VA       = 6;
    localparam int          VT       = 12;
    localparam int          HSP      = 3;
    localparam logic [24:0] RST_ADDR = 25'h1ABCDE;
    localparam int          FRAME    = HT * VT;
    localparam int          B_OFF    = (VB + VA - 1) * HT + HT - 1;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    localparam int          FC_AFTER_3 = 3;
`else
    localparam int          FC_AFTER_3 = 0;
`endif

    logic        clk_video;
    logic        reset_n;
    logic [9:0]  x_count;
    logic [9:0]  y_count;
    logic        line_start;
    logic        vid_hs;
    logic        vid_vs;
    logic        vid_de;
    logic        vblank;
    logic [15:0] frame_count;

    video_timing_fb_swap_if swap_bus ();

    video_timing_fb_swap #(
        .H_BPORCH(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_BPORCH(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
        .HS_POS(HSP), .RESET_FB_ADDR(RST_ADDR)
    ) dut (
        .clk_video  (clk_video),
        .reset_n    (reset_n),
        .x_count    (x_count),
        .y_count    (y_count),
        .line_start (line_start),
        .vid_hs     (vid_hs),
        .vid_vs     (vid_vs),
        .vid_de     (vid_de),
        .vblank     (vblank),
        .frame_count(frame_count),
        .swap_bus   (swap_bus)
    );

    typedef struct {
        int          t;
        logic [24:0] addr;
    } req_t;

    req_t reqs[$];
    int   t;
    int   vectors;
    int   miscompares;
    bit   model_on;

    initial clk_video = 1'b0;
    always #5 clk_video = ~clk_video;

    // t = clock edges since reset release; every model rule is a function of it.
    always @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) t <= 0;
        else          t <= t + 1;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at t=%0d: got %0h, expected %0h", name, t, actual, expected);
        end
    endtask

    function automatic int next_boundary(input int rt);
        if (rt < B_OFF) return B_OFF;
        return B_OFF + ((rt - B_OFF) / FRAME + 1) * FRAME;
    endfunction

    function automatic bit active_at(input int tt);
        int xx;
        int yy;
        xx = tt % HT;
        yy = (tt / HT) % VT;
        return (xx >= HB) && (xx < HB + HA) && (yy >= VB) && (yy < VB + VA);
    endfunction

    // The front buffer holds the latest request whose following boundary has already passed.
    function automatic logic [24:0] exp_fb(input int tt);
        logic [24:0] res;
        res = RST_ADDR;
        foreach (reqs[i]) if (next_boundary(reqs[i].t) < tt) res = reqs[i].addr;
        return res;
    endfunction

    function automatic bit exp_done(input int tt);
        bit res;
        res = 1'b0;
        foreach (reqs[i]) if (next_boundary(reqs[i].t) == tt - 1) res = 1'b1;
        return res;
    endfunction

    function automatic bit exp_pending(input int tt);
        bit res;
        res = 1'b0;
        foreach (reqs[i]) if (reqs[i].t < tt && next_boundary(reqs[i].t) >= tt) res = 1'b1;
        return res;
    endfunction

    always @(negedge clk_video) begin : compare
        int  xe;
        int  ye;
        int  xp;
        int  yp;
        int  fe;
        xe = t % HT;
        ye = (t / HT) % VT;
        xp = (t - 1) % HT;
        yp = ((t - 1) / HT) % VT;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        fe = (t / FRAME) % 65536;
`else
        fe = 0;
`endif
        if (reset_n && model_on) begin
            check_output("x_count", 32'(x_count), xe);
            check_output("y_count", 32'(y_count), ye);
            check_output("line_start", 32'(line_start), 32'(xe == 0));
            check_output("vblank", 32'(vblank), 32'(!(ye >= VB && ye < VB + VA)));
            check_output("vid_de", 32'(vid_de), 32'(t > 0 && active_at(t - 1)));
            check_output("vid_hs", 32'(vid_hs), 32'(t > 0 && xp == HSP));
            check_output("vid_vs", 32'(vid_vs), 32'(t > 0 && xp == HSP && yp == 0));
            check_output("fb_base_addr", 32'(swap_bus.fb_base_addr), 32'(exp_fb(t)));
            check_output("swap_pending", 32'(swap_bus.swap_pending), 32'(exp_pending(t)));
            check_output("swap_done", 32'(swap_bus.swap_done), 32'(exp_done(t)));
            check_output("frame_count", 32'(frame_count), fe);
        end
    end

    task automatic goto_cycle(input int target);
        int guard;
        guard = 0;
        while (t < target && guard < 50000) begin
            @(negedge clk_video);
            guard++;
        end
        if (t != target) begin
            miscompares++;
            $display("[TB] FAIL goto_cycle: reached t=%0d, wanted %0d", t, target);
        end
    endtask

    task automatic apply_stimulus(input logic [24:0] addr);
        req_t r;
        r.t    = t;
        r.addr = addr;
        reqs.push_back(r);
        swap_bus.back_addr = addr;
        swap_bus.swap_req  = 1'b1;
        @(negedge clk_video);
        swap_bus.swap_req  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, " x"}, 32'(x_count), 0);
        check_output({tag, " y"}, 32'(y_count), 0);
        check_output({tag, " line_start"}, 32'(line_start), 1);
        check_output({tag, " vblank"}, 32'(vblank), 1);
        check_output({tag, " de/hs/vs"}, 32'({vid_de, vid_hs, vid_vs}), 0);
        check_output({tag, " fb"}, 32'(swap_bus.fb_base_addr), 32'(RST_ADDR));
        check_output({tag, " pending"}, 32'(swap_bus.swap_pending), 0);
        check_output({tag, " done"}, 32'(swap_bus.swap_done), 0);
        check_output({tag, " frame_count"}, 32'(frame_count), 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_on    = 1'b0;
        reset_n     = 1'b0;
        swap_bus.swap_req  = 1'b0;
        swap_bus.back_addr = 25'h0;
        repeat (3) @(negedge clk_video);
        check_reset_state("in_reset");
        reset_n  = 1'b1;
        model_on = 1'b1;
        check_reset_state("release");

        goto_cycle(4);
        check_output("hs first line", 32'(vid_hs), 1);
        check_output("vs first frame", 32'(vid_vs), 1);
        goto_cycle(20);
        check_output("line1 x", 32'(x_count), 0);
        check_output("line1 y", 32'(y_count), 1);
        goto_cycle(24);
        check_output("hs line1", 32'(vid_hs), 1);
        check_output("vs line1", 32'(vid_vs), 0);

        goto_cycle(65);
        check_output("de before window", 32'(vid_de), 0);
        check_output("vblank active row", 32'(vblank), 0);
        goto_cycle(66);
        check_output("de first pixel", 32'(vid_de), 1);
        goto_cycle(75);
        check_output("de last pixel", 32'(vid_de), 1);
        goto_cycle(76);
        check_output("de after window", 32'(vid_de), 0);

        goto_cycle(240);
        check_output("frame wrap y", 32'(y_count), 0);
        goto_cycle(244);
        check_output("vs frame1", 32'(vid_vs), 1);

        goto_cycle(320);
        apply_stimulus(25'h12C00);
        goto_cycle(419);
        check_output("fb held to B", 32'(swap_bus.fb_base_addr), 32'(RST_ADDR));
        check_output("pending before B", 32'(swap_bus.swap_pending), 1);
        goto_cycle(420);
        check_output("fb after B", 32'(swap_bus.fb_base_addr), 32'h12C00);
        check_output("done after B", 32'(swap_bus.swap_done), 1);
        check_output("pending cleared", 32'(swap_bus.swap_pending), 0);
        goto_cycle(421);
        check_output("done single pulse", 32'(swap_bus.swap_done), 0);

        goto_cycle(500);
        apply_stimulus(25'hA);
        goto_cycle(550);
        apply_stimulus(25'hB);
        goto_cycle(659);
        apply_stimulus(25'hC);
        check_output("last wins", 32'(swap_bus.fb_base_addr), 32'hB);
        check_output("done last wins", 32'(swap_bus.swap_done), 1);
        check_output("C still pending", 32'(swap_bus.swap_pending), 1);
        goto_cycle(900);
        check_output("C next frame", 32'(swap_bus.fb_base_addr), 32'hC);
        check_output("C done", 32'(swap_bus.swap_done), 1);
        check_output("frame_count 3", 32'(frame_count), FC_AFTER_3);

        goto_cycle(1060);
        apply_stimulus(25'h55);
        check_output("pending before reset", 32'(swap_bus.swap_pending), 1);
        reset_n = 1'b0;
        #1;
        check_reset_state("async reset");
        reqs.delete();
        @(negedge clk_video);
        @(negedge clk_video);
        reset_n = 1'b1;
        check_reset_state("re-release");

        goto_cycle(720);
        check_output("frame_count after reset", 32'(frame_count), FC_AFTER_3);
        check_output("discarded swap", 32'(swap_bus.fb_base_addr), 32'(RST_ADDR));
        @(negedge clk_video);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_timing_fb_swap.md
Name: video_timing_fb_swap

Overview:
- Pixel-clock timing generator and double-buffer controller; sits directly upstream of the line-buffered SDRAM scanout stage.
- Produces x_count/y_count/line_start consumed by scanout, plus one-cycle-delayed hs/vs/de aligned with scanout's registered pixel_color.
- Latches CPU back-buffer address requests and commits them to fb_base_addr only at the active-to-vblank boundary, so no scanline prefetch ever sees a mid-frame address change.

Parameters:
H_BPORCH, 40, first active x
H_ACTIVE, 320, active pixels per line
H_TOTAL, 400, clocks per line (x wraps at H_TOTAL-1)
V_BPORCH, 16, first active y
V_ACTIVE, 240, active lines
V_TOTAL, 512, lines per frame (400x512 at 12.288 MHz = 60 Hz)
HS_POS, 3, x position of hsync pulse
RESET_FB_ADDR, 25'h0, fb_base_addr after reset

Ports:
clk_video  in  1  pixel clock, 12.288 MHz
reset_n  in  1  asynchronous active-low reset
x_count  out  10  horizontal counter, 0..H_TOTAL-1
y_count  out  10  vertical counter, 0..V_TOTAL-1
line_start  out  1  high exactly when x_count==0
vid_hs  out  1  one-cycle hsync pulse
vid_vs  out  1  one-cycle vsync pulse
vid_de  out  1  data enable, aligned with scanout pixel_color
vblank  out  1  high while y_count outside active rows
back_addr  in  25  requested next front-buffer SDRAM word address
swap_req  in  1  one-cycle request: capture back_addr, swap at next boundary
fb_base_addr  out  25  current front-buffer address to scanout
swap_pending  out  1  request captured, not yet applied
swap_done  out  1  one-cycle pulse when fb_base_addr updates
frame_count  out  16  frame counter (optional feature)

Behaviour:
- Reset, async assert: all counters, flags and pulses 0; fb_base_addr=RESET_FB_ADDR; pending_addr=0; vblank=1. Reset mid-frame restarts at x=0,y=0; a pending swap is discarded.
- Counters, all registered:
  - x increments each clock; at H_TOTAL-1 it wraps to 0 and y increments.
  - y wraps to 0 after V_TOTAL-1, in the same cycle x wraps.
- line_start: combinational decode of registered x_count==0, so it is coincident with x_count.
- Active window: act = (H_BPORCH<=x<H_BPORCH+H_ACTIVE) && (V_BPORCH<=y<V_BPORCH+V_ACTIVE).
  - vid_de is act registered: 1-cycle latency matching scanout's registered pixel.
  - Defaults: de high for registered x 41..360 on lines y 16..255.
- vid_hs: registered (x==HS_POS), high one cycle per line.
- vid_vs: registered (x==HS_POS && y==0), high one cycle per frame. Both carry the same 1-cycle delay as vid_de.
- vblank: combinational !(V_BPORCH<=y<V_BPORCH+V_ACTIVE).
- Swap FSM, states IDLE and PENDING:
  - IDLE: swap_req -> pending_addr<=back_addr, go PENDING.
  - PENDING: swap_req -> pending_addr<=back_addr, last request wins, stay PENDING.
  - Boundary cycle B = (x==H_TOTAL-1 && y==V_BPORCH+V_ACTIVE-1), i.e. the last clock of the last active line.
  - In PENDING at B: fb_base_addr<=pending_addr; swap_done=1 next cycle for one cycle; go IDLE.
  - swap_req in the same cycle as B, while PENDING: the old pending_addr is applied; the new address is captured and the FSM stays PENDING for the next frame's B.
  - swap_req at B while IDLE: captured, go PENDING; applied at the following frame's B.
  - swap_pending = (state==PENDING).
- fb_base_addr is never written outside B. Scanout prefetch for line 0 (at y=V_BPORCH-1) therefore always sees a stable address.
- No arithmetic beyond 10-bit counters; parameters must satisfy H_TOTAL, V_TOTAL <= 1024.

Optional Feature:
- Macro: VIDEO_TIMING_FRAME_CNT_EN.
- Defined: frame_count is a 16-bit register that increments in the cycle x and y both wrap to 0 and rolls 16'hFFFF->0. Reset 0.
- Undefined: frame_count is tied to 16'h0 and no register is inferred.

Test Plan:
- Reset release -> x_count=0,y_count=0,line_start=1 first cycle; after 400 clocks x=0,y=1; after 204800 clocks y=0 again.
- Line y=16 -> vid_de low through registered x=40, high for x=41..360 (320 cycles), low from x=361; lines 15 and 256 show no de.
- Free run 2 frames -> vid_hs exactly 512 pulses/frame at delayed x=4; vid_vs one pulse/frame coincident with the y=0 hs.
- swap_req with back_addr=25'h12C00 at y=100 -> fb_base_addr unchanged until cycle after x=399,y=255; then 25'h12C00, swap_done single pulse, swap_pending 1->0.
- Two requests, 25'hA and 25'hB, in one frame -> only 25'hB applied, one swap_done. Request 25'hC exactly at B while 25'hB is pending -> 25'hB applied this frame, 25'hC next frame.
- Assert reset_n low at y=200 with a swap pending -> outputs clear asynchronously, fb_base_addr=RESET_FB_ADDR, swap_pending=0. With the macro defined, frame_count=0 and it reads 3 after 3 full frames.
